// File: rtl/io_port_bank.sv
// io_port_bank
// Memory-mapped I/O port bank for the 8-bit CPU datapath.
// Provides NPORTS = 2**ADDR_W output ports with load/set/clear/toggle writes,
// and NPORTS input ports with two-flop synchronisers, change detection and
// sticky per-port change flags. CPU reads are registered with a one-cycle
// rvalid pulse.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   we         write strobe for output port addr
//   wmode      00 load, 01 set (OR), 10 clear (AND NOT), 11 toggle (XOR)
//   wdata      write data / bit mask
//   re         read strobe for input port addr
//   addr       port select, shared by read and write
//   rdata      registered read data (synchronised pin value)
//   rvalid     one-cycle pulse when rdata is updated
//   in_ports   asynchronous external inputs, port i = [i*WIDTH +: WIDTH]
//   out_ports  registered outputs, same packing
//   in_flag    sticky change flag per input port
//   irq        OR of all in_flag bits (combinational)

module io_port_bank #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 2,
  localparam int unsigned NPORTS = 1 << ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [1:0]                wmode,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      re,
  input  logic [ADDR_W-1:0]         addr,
  output logic [WIDTH-1:0]          rdata,
  output logic                      rvalid,
  input  logic [NPORTS*WIDTH-1:0]   in_ports,
  output logic [NPORTS*WIDTH-1:0]   out_ports,
  output logic [NPORTS-1:0]         in_flag,
  output logic                      irq
);

  typedef enum logic [1:0] {
    WM_LOAD   = 2'b00,
    WM_SET    = 2'b01,
    WM_CLEAR  = 2'b10,
    WM_TOGGLE = 2'b11
  } wmode_e;

  // Output port registers
  logic [WIDTH-1:0]  r_out   [NPORTS];
  // Input path: synchroniser stages and previous synchronised value
  logic [WIDTH-1:0]  r_sync1 [NPORTS];
  logic [WIDTH-1:0]  r_sync2 [NPORTS];
  logic [WIDTH-1:0]  r_prev  [NPORTS];
  // Sticky change flags and registered read port
  logic [NPORTS-1:0] r_flag;
  logic [WIDTH-1:0]  r_rdata;
  logic              r_rvalid;

  wmode_e            w_mode;
  logic [WIDTH-1:0]  w_cur;
  logic [WIDTH-1:0]  w_wr_val;
  logic [NPORTS-1:0] w_change;
  logic [NPORTS-1:0] w_rd_clr;
  logic [NPORTS-1:0] w_flag_nxt;

  assign w_mode = wmode_e'(wmode);
  assign w_cur  = r_out[addr];

  // Read-modify-write result for the addressed output port
  always_comb begin
    w_wr_val = w_cur;
    unique case (w_mode)
      WM_LOAD:   w_wr_val = wdata;
      WM_SET:    w_wr_val = w_cur | wdata;
      WM_CLEAR:  w_wr_val = w_cur & ~wdata;
      WM_TOGGLE: w_wr_val = w_cur ^ wdata;
      default:   w_wr_val = w_cur;
    endcase
  end

  // Change detection and read-clear per port; a set on the same edge wins
  always_comb begin
    w_change   = '0;
    w_rd_clr   = '0;
    w_flag_nxt = '0;
    for (int i = 0; i < int'(NPORTS); i++) begin
      w_change[i] = (r_sync2[i] != r_prev[i]);
      w_rd_clr[i] = re && (addr == ADDR_W'(i));
    end
    w_flag_nxt = (r_flag & ~w_rd_clr) | w_change;
  end

  // Output port write registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NPORTS); i++) begin
        r_out[i] <= '0;
      end
    end else if (we) begin
      r_out[addr] <= w_wr_val;
    end
  end

  // Input synchronisers and previous-value registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NPORTS); i++) begin
        r_sync1[i] <= '0;
        r_sync2[i] <= '0;
        r_prev[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NPORTS); i++) begin
        r_sync1[i] <= in_ports[i*WIDTH +: WIDTH];
        r_sync2[i] <= r_sync1[i];
        r_prev[i]  <= r_sync2[i];
      end
    end
  end

  // Sticky change flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flag <= '0;
    end else begin
      r_flag <= w_flag_nxt;
    end
  end

  // Registered read port; rdata holds between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= re;
      if (re) begin
        r_rdata <= r_sync2[addr];
      end
    end
  end

  // Pack output registers onto the flat port bus
  for (genvar g = 0; g < int'(NPORTS); g++) begin : g_out_pack
    assign out_ports[g*WIDTH +: WIDTH] = r_out[g];
  end

  assign rdata   = r_rdata;
  assign rvalid  = r_rvalid;
  assign in_flag = r_flag;
  assign irq     = |r_flag;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed testbench for io_port_bank: default instance (WIDTH=8, ADDR_W=2)
// plus a wide instance (WIDTH=16, ADDR_W=3) for the back-to-back read sweep.

module tb_io_port_bank;

  logic         clk;
  logic         reset;

  // Default instance
  logic         we, re;
  logic [1:0]   wmode;
  logic [7:0]   wdata;
  logic [1:0]   addr;
  logic [7:0]   rdata;
  logic         rvalid;
  logic [31:0]  in_ports;
  logic [31:0]  out_ports;
  logic [3:0]   in_flag;
  logic         irq;

  // Wide instance
  logic         we_b, re_b;
  logic [1:0]   wmode_b;
  logic [15:0]  wdata_b;
  logic [2:0]   addr_b;
  logic [15:0]  rdata_b;
  logic         rvalid_b;
  logic [127:0] in_ports_b;
  logic [127:0] out_ports_b;
  logic [7:0]   in_flag_b;
  logic         irq_b;

  int unsigned  n_checks;
  int unsigned  n_fail;

  io_port_bank #(.WIDTH(8), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .we(we), .wmode(wmode), .wdata(wdata),
    .re(re), .addr(addr), .rdata(rdata), .rvalid(rvalid),
    .in_ports(in_ports), .out_ports(out_ports), .in_flag(in_flag), .irq(irq)
  );

  io_port_bank #(.WIDTH(16), .ADDR_W(3)) dut_b (
    .clk(clk), .reset(reset), .we(we_b), .wmode(wmode_b), .wdata(wdata_b),
    .re(re_b), .addr(addr_b), .rdata(rdata_b), .rvalid(rvalid_b),
    .in_ports(in_ports_b), .out_ports(out_ports_b), .in_flag(in_flag_b),
    .irq(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pin_b(input int i);
    return 16'hA000 | 16'(i * 16'h0111);
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    we = 1'b0; re = 1'b0; wmode = 2'b00; wdata = 8'h00; addr = 2'd0;
    in_ports = 32'h0;
    we_b = 1'b0; re_b = 1'b0; wmode_b = 2'b00; wdata_b = 16'h0; addr_b = 3'd0;
    for (int i = 0; i < 8; i++) in_ports_b[i*16 +: 16] = pin_b(i);

    tick(); tick();
    check("rst_out",    out_ports, 32'h0);
    check("rst_rdata",  rdata,     32'h0);
    check("rst_rvalid", rvalid,    32'h0);
    check("rst_flag",   in_flag,   32'h0);
    check("rst_irq",    irq,       32'h0);
    reset = 1'b0;

    // Load then modify chain on port 2
    we = 1'b1; addr = 2'd2; wmode = 2'b00; wdata = 8'hA5;
    tick();
    check("load_p2", out_ports, 32'h00A50000);
    wmode = 2'b01; wdata = 8'h10;
    tick();
    check("set_p2", out_ports, 32'h00B50000);
    wmode = 2'b10; wdata = 8'h80;
    tick();
    check("clr_p2", out_ports, 32'h00350000);
    wmode = 2'b11; wdata = 8'hFF;
    tick();
    check("tgl_p2", out_ports, 32'h00CA0000);
    we = 1'b0; wdata = 8'h00;
    tick();
    check("hold_p2", out_ports, 32'h00CA0000);

    // Input change on port 1: flag at E2
    in_ports = 32'h00003C00;
    tick();
    check("chg_E0_flag", in_flag, 32'h0);
    tick();
    check("chg_E1_flag", in_flag, 32'h0);
    tick();
    check("chg_E2_flag", in_flag, 32'h2);
    check("chg_E2_irq",  irq,     32'h1);
    re = 1'b1; addr = 2'd1;
    tick();
    check("rd_p1_data",  rdata,   32'h3C);
    check("rd_p1_valid", rvalid,  32'h1);
    check("rd_p1_clr",   in_flag, 32'h0);
    check("rd_p1_irq",   irq,     32'h0);
    re = 1'b0;
    tick();
    check("rd_idle_valid", rvalid, 32'h0);
    check("rd_idle_hold",  rdata,  32'h3C);

    // Collision: read of port 0 on the edge its change is detected
    in_ports = 32'h00003C55;
    tick();
    tick();
    re = 1'b1; addr = 2'd0;
    tick();
    check("coll_data",  rdata,   32'h55);
    check("coll_valid", rvalid,  32'h1);
    check("coll_flag",  in_flag, 32'h1);
    tick();
    check("coll_rd2_valid", rvalid,  32'h1);
    check("coll_rd2_clr",   in_flag, 32'h0);

    // Simultaneous write and read
    we = 1'b1; wmode = 2'b00; wdata = 8'h11; addr = 2'd3;
    tick();
    check("wr_rd_out",   out_ports, 32'h11CA0000);
    check("wr_rd_data",  rdata,     32'h00);
    check("wr_rd_valid", rvalid,    32'h1);
    we = 1'b0; re = 1'b0;
    tick();

    // Async reset between edges
    #2;
    reset = 1'b1;
    in_ports = 32'h01000000;
    #1;
    check("arst_out",    out_ports, 32'h0);
    check("arst_rdata",  rdata,     32'h0);
    check("arst_flag",   in_flag,   32'h0);
    check("arst_b_out",  out_ports_b[31:0], 32'h0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("rel_E2_flag", in_flag, 32'h0);
    tick();
    check("rel_E3_flag", in_flag,   32'h8);
    check("rel_E3_irq",  irq,       32'h1);
    check("wide_flags",  in_flag_b, 32'hFF);

    // Wide instance: back-to-back reads of all 8 ports
    re_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr_b = 3'(i);
      tick();
      check($sformatf("wide_rv%0d", i), rvalid_b, 32'h1);
      check($sformatf("wide_rd%0d", i), rdata_b,  32'(pin_b(i)));
    end
    re_b = 1'b0;
    tick();
    check("wide_rv_end", rvalid_b,  32'h0);
    check("wide_clr",    in_flag_b, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
